// File: rtl/can_err_pkg.sv
// can_err_pkg: shared FSM states, error-state encodings and fault-confinement limits
package can_err_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLAG   = 2'd1,
        ST_DELIM  = 2'd2,
        ST_BUSOFF = 2'd3
    } fsm_state_t;

    localparam logic [1:0] ES_ACTIVE  = 2'b00;
    localparam logic [1:0] ES_PASSIVE = 2'b01;
    localparam logic [1:0] ES_BUSOFF  = 2'b10;

    localparam logic [8:0] TEC_INC     = 9'd8;
    localparam logic [8:0] PASSIVE_LIM = 9'd128;
    localparam logic [8:0] BUSOFF_LIM  = 9'd256;
    localparam logic [8:0] WARN_LIM    = 9'd96;
    localparam logic [7:0] REC_RESTORE = 8'd120;
    localparam logic [3:0] RECOV_BITS  = 4'd11;
    localparam logic [7:0] RECOV_SEQ   = 8'd128;

endpackage

// File: rtl/can_busoff_recovery.sv
// can_busoff_recovery: counts 128 runs of 11 recessive bits while enabled; done pulses on the final bit
module can_busoff_recovery
    import can_err_pkg::*;
(
    input  logic SP,
    input  logic reset,
    input  logic enable,
    input  logic RX_BIT,
    output logic done
);

    logic [3:0] bits_q, bits_d;
    logic [7:0] seq_q, seq_d;
    logic       last_bit, last_seq;

    assign last_bit = bits_q == RECOV_BITS - 4'd1;
    assign last_seq = seq_q == RECOV_SEQ - 8'd1;
    assign done     = enable && RX_BIT && last_bit && last_seq;

    // a dominant bit restarts the current run but keeps completed sequences
    always_comb begin
        bits_d = (!enable || !RX_BIT || last_bit) ? 4'd0 : bits_q + 4'd1;
        seq_d  = !enable ? 8'd0 : (RX_BIT && last_bit) ? (last_seq ? 8'd0 : seq_q + 8'd1) : seq_q;
    end

    always_ff @(posedge SP) begin
        if (reset) begin
            bits_q <= '0;
            seq_q  <= '0;
        end else begin
            bits_q <= bits_d;
            seq_q  <= seq_d;
        end
    end

endmodule

// File: rtl/error_confinement_ctrl.sv
// error_confinement_ctrl: CAN-style TEC/REC fault confinement with error flag/delimiter sequencing and bus-off recovery.
// Define ERR_WARNING_EN to add the ERR_WARN output (TEC>=96 or REC>=96).
module error_confinement_ctrl
    import can_err_pkg::*;
#(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8
)
(
    input  logic       SP,
    input  logic       reset,
    input  logic       STF_E,
    input  logic       EOF_E,
    input  logic       CRC_E,
    input  logic       FRM_E,
    input  logic       TX_MODE,
    input  logic       FRAME_OK,
    input  logic       RX_BIT,
    output logic [8:0] TEC,
    output logic [7:0] REC,
    output logic [1:0] ERR_STATE,
    output logic       FLAG_TX,
    output logic       FLAG_PASSIVE,
`ifdef ERR_WARNING_EN
    output logic       ERR_WARN,
`endif
    output logic       DELIM_TX
);

    localparam int CW = $clog2((FLAG_LEN > DELIM_LEN ? FLAG_LEN : DELIM_LEN) + 1);

    fsm_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    tec_q, tec_d, tec_sum;
    logic [7:0]    rec_q, rec_d;
    logic          fpass_q, fpass_d, flag_tx_q, delim_tx_q;
    logic          err_ev, rec_done;
    logic [1:0]    err_state;

    assign err_ev    = !(STF_E && EOF_E && CRC_E && FRM_E);
    assign tec_sum   = tec_q + TEC_INC;
    assign err_state = (tec_q >= BUSOFF_LIM) ? ES_BUSOFF :
                       (tec_q >= PASSIVE_LIM || {1'b0, rec_q} >= PASSIVE_LIM) ? ES_PASSIVE : ES_ACTIVE;

    can_busoff_recovery u_recovery (
        .SP     (SP),
        .reset  (reset),
        .enable (state_q == ST_BUSOFF),
        .RX_BIT (RX_BIT),
        .done   (rec_done)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tec_d   = tec_q;
        rec_d   = rec_q;
        fpass_d = fpass_q;
        // bus-off pre-empts an in-progress flag or delimiter
        if (state_q != ST_BUSOFF && tec_q >= BUSOFF_LIM) begin
            state_d = ST_BUSOFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (err_ev) begin
                        state_d = ST_FLAG;
                        cnt_d   = CW'(FLAG_LEN - 1);
                        fpass_d = err_state == ES_PASSIVE;
                        tec_d   = TX_MODE ? ((tec_sum > BUSOFF_LIM) ? BUSOFF_LIM : tec_sum) : tec_q;
                        rec_d   = (!TX_MODE && rec_q != 8'hFF) ? rec_q + 8'd1 : rec_q;
                    end else if (FRAME_OK) begin
                        tec_d = (TX_MODE && tec_q != 9'd0) ? tec_q - 9'd1 : tec_q;
                        rec_d = TX_MODE ? rec_q :
                                ({1'b0, rec_q} >= PASSIVE_LIM) ? REC_RESTORE :
                                (rec_q != 8'd0) ? rec_q - 8'd1 : rec_q;
                    end
                end
                ST_FLAG: begin
                    state_d = (cnt_q == '0) ? ST_DELIM : ST_FLAG;
                    cnt_d   = (cnt_q == '0) ? CW'(DELIM_LEN - 1) : cnt_q - CW'(1);
                end
                ST_DELIM: begin
                    state_d = (cnt_q == '0) ? ST_IDLE : ST_DELIM;
                    cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                end
                default: begin
                    state_d = rec_done ? ST_IDLE : ST_BUSOFF;
                    tec_d   = rec_done ? 9'd0 : tec_q;
                    rec_d   = rec_done ? 8'd0 : rec_q;
                end
            endcase
        end
    end

    always_ff @(posedge SP) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tec_q      <= '0;
            rec_q      <= '0;
            fpass_q    <= 1'b0;
            flag_tx_q  <= 1'b0;
            delim_tx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tec_q      <= tec_d;
            rec_q      <= rec_d;
            fpass_q    <= fpass_d;
            flag_tx_q  <= state_d == ST_FLAG;
            delim_tx_q <= state_d == ST_DELIM;
        end
    end

    assign TEC          = tec_q;
    assign REC          = rec_q;
    assign ERR_STATE    = err_state;
    assign FLAG_TX      = flag_tx_q;
    assign DELIM_TX     = delim_tx_q;
    assign FLAG_PASSIVE = fpass_q;
`ifdef ERR_WARNING_EN
    assign ERR_WARN     = tec_q >= WARN_LIM || {1'b0, rec_q} >= WARN_LIM;
`endif

endmodule

// File: tb/tb_error_confinement_ctrl.sv
// tb_error_confinement_ctrl: directed scenarios plus randomized traffic checked against a counter-level model.
// Define ERR_WARNING_EN to also check the ERR_WARN output.
module tb_error_confinement_ctrl;

    localparam int FL = 6;
    localparam int DL = 8;

    logic       SP = 1'b0;
    logic       reset = 1'b1, STF_E = 1'b1, EOF_E = 1'b1, CRC_E = 1'b1, FRM_E = 1'b1;
    logic       TX_MODE = 1'b0, FRAME_OK = 1'b0, RX_BIT = 1'b1;
    logic [8:0] TEC;
    logic [7:0] REC;
    logic [1:0] ERR_STATE;
    logic       FLAG_TX, FLAG_PASSIVE, DELIM_TX;
`ifdef ERR_WARNING_EN
    logic       ERR_WARN;
`endif

    error_confinement_ctrl #(.FLAG_LEN(FL), .DELIM_LEN(DL)) dut (
        .SP(SP), .reset(reset), .STF_E(STF_E), .EOF_E(EOF_E), .CRC_E(CRC_E), .FRM_E(FRM_E),
        .TX_MODE(TX_MODE), .FRAME_OK(FRAME_OK), .RX_BIT(RX_BIT),
        .TEC(TEC), .REC(REC), .ERR_STATE(ERR_STATE), .FLAG_TX(FLAG_TX), .FLAG_PASSIVE(FLAG_PASSIVE),
`ifdef ERR_WARNING_EN
        .ERR_WARN(ERR_WARN),
`endif
        .DELIM_TX(DELIM_TX)
    );

    always #5 SP = ~SP;

    int checks = 0, errors = 0;

    // model: counters plus "bit times left in the current error frame" and bus-off recovery progress
    int m_tec, m_rec, m_busy, m_run, m_seq;
    bit m_boff, m_fpass;

    function automatic logic [1:0] m_state();
        return (m_tec >= 256) ? 2'b10 : (m_tec >= 128 || m_rec >= 128) ? 2'b01 : 2'b00;
    endfunction

    task automatic model(input bit err, input bit fok, input bit tx, input bit rx, input bit rst);
        if (rst) begin
            m_tec = 0; m_rec = 0; m_busy = 0; m_run = 0; m_seq = 0; m_boff = 0; m_fpass = 0;
        end else if (m_boff) begin
            m_run = rx ? m_run + 1 : 0;
            if (m_run == 11) begin
                m_run = 0;
                m_seq++;
                if (m_seq == 128) begin
                    m_boff = 0; m_seq = 0; m_tec = 0; m_rec = 0;
                end
            end
        end else if (m_tec >= 256) begin
            m_boff = 1; m_busy = 0; m_run = 0; m_seq = 0;
        end else if (m_busy > 0) begin
            m_busy--;
        end else if (err) begin
            m_fpass = m_state() == 2'b01;
            m_busy = FL + DL;
            if (tx) m_tec = (m_tec + 8 > 256) ? 256 : m_tec + 8;
            else    m_rec = (m_rec + 1 > 255) ? 255 : m_rec + 1;
        end else if (fok) begin
            if (tx) m_tec = (m_tec > 0) ? m_tec - 1 : 0;
            else    m_rec = (m_rec > 127) ? 120 : (m_rec > 0) ? m_rec - 1 : 0;
        end
    endtask

    task automatic cyc(input bit err, input bit fok, input bit tx, input bit rx, input bit rst);
        logic [3:0] f;
        f = 4'hF;
        if (err) f[$urandom_range(0, 3)] = 1'b0;
        {STF_E, EOF_E, CRC_E, FRM_E} = f;
        FRAME_OK = fok; TX_MODE = tx; RX_BIT = rx; reset = rst;
        @(posedge SP);
        model(err, fok, tx, rx, rst);
        #1;
    endtask

    // n error frames, each run to completion with the bus held dominant
    task automatic errs(input int n, input bit tx);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, tx, 0, 0);
            repeat (FL + DL) cyc(0, 0, tx, 0, 0);
        end
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 1);
        checks++; if (TEC !== 9'd0) begin errors++; $display("FAIL reset_tec: got %0d want 0", TEC); end
        checks++; if (REC !== 8'd0) begin errors++; $display("FAIL reset_rec: got %0d want 0", REC); end
        checks++; if (ERR_STATE !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", ERR_STATE); end
        checks++; if ({FLAG_TX, DELIM_TX, FLAG_PASSIVE} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b want 000", {FLAG_TX, DELIM_TX, FLAG_PASSIVE});
        end
    endtask

    task automatic test_tx_error();
        int nf, nd;
        bit order_ok;
        cyc(0, 0, 0, 1, 1);
        CRC_E = 1'b0; FRAME_OK = 1'b0; TX_MODE = 1'b1; reset = 1'b0;
        @(posedge SP); model(1, 0, 1, 1, 0); #1;
        CRC_E = 1'b1;
        checks++; if (FLAG_TX !== 1'b1) begin errors++; $display("FAIL tx_flag_first: got %b want 1", FLAG_TX); end
        checks++; if (TEC !== 9'd8) begin errors++; $display("FAIL tx_tec: got %0d want 8", TEC); end
        checks++; if (FLAG_PASSIVE !== 1'b0) begin errors++; $display("FAIL tx_fpass: got %b want 0", FLAG_PASSIVE); end
        nf = 1; nd = 0; order_ok = 1;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 1, 1, 0);
            nf += int'(FLAG_TX);
            nd += int'(DELIM_TX);
            if (FLAG_TX && nd > 0) order_ok = 0;
        end
        checks++; if (nf != FL) begin errors++; $display("FAIL tx_flag_len: got %0d want %0d", nf, FL); end
        checks++; if (nd != DL || !order_ok) begin errors++; $display("FAIL tx_delim_len: got %0d (order %0b) want %0d", nd, order_ok, DL); end
    endtask

    task automatic test_passive();
        cyc(0, 0, 0, 1, 1);
        errs(16, 1);
        checks++; if (TEC !== 9'd128) begin errors++; $display("FAIL passive_tec: got %0d want 128", TEC); end
        checks++; if (ERR_STATE !== 2'b01) begin errors++; $display("FAIL passive_state: got %b want 01", ERR_STATE); end
        cyc(1, 0, 1, 0, 0);
        checks++; if (FLAG_PASSIVE !== 1'b1 || FLAG_TX !== 1'b1) begin
            errors++; $display("FAIL passive_flag: got fpass=%b flag=%b want 1 1", FLAG_PASSIVE, FLAG_TX);
        end
    endtask

    task automatic test_rec_restore();
        cyc(0, 0, 0, 1, 1);
        errs(130, 0);
        checks++; if (REC !== 8'd130 || ERR_STATE !== 2'b01) begin
            errors++; $display("FAIL rec_setup: got rec=%0d state=%b want 130 01", REC, ERR_STATE);
        end
        cyc(0, 1, 0, 0, 0);
        checks++; if (REC !== 8'd120 || ERR_STATE !== 2'b00) begin
            errors++; $display("FAIL rec_restore: got rec=%0d state=%b want 120 00", REC, ERR_STATE);
        end
        cyc(0, 1, 0, 0, 0);
        checks++; if (REC !== 8'd119) begin errors++; $display("FAIL rec_dec: got %0d want 119", REC); end
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 0);
        checks++; if (REC !== 8'd0) begin errors++; $display("FAIL rec_zero: got %0d want 0", REC); end
    endtask

    task automatic test_err_and_ok();
        int nf, nd;
        cyc(0, 0, 0, 1, 1);
        errs(2, 1);
        repeat (6) cyc(0, 1, 1, 0, 0);
        checks++; if (TEC !== 9'd10) begin errors++; $display("FAIL both_setup: got %0d want 10", TEC); end
        FRM_E = 1'b0; FRAME_OK = 1'b1; TX_MODE = 1'b1;
        @(posedge SP); model(1, 1, 1, 0, 0); #1;
        FRM_E = 1'b1;
        checks++; if (TEC !== 9'd18) begin errors++; $display("FAIL both_tec: got %0d want 18", TEC); end
        nf = int'(FLAG_TX); nd = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(i == 1, 0, 1, 0, 0);
            nf += int'(FLAG_TX);
            nd += int'(DELIM_TX);
        end
        checks++; if (TEC !== 9'd18) begin errors++; $display("FAIL ignore_tec: got %0d want 18", TEC); end
        checks++; if (nf != FL || nd != DL) begin
            errors++; $display("FAIL ignore_len: got flag=%0d delim=%0d want %0d %0d", nf, nd, FL, DL);
        end
    endtask

    task automatic test_busoff();
        cyc(0, 0, 0, 1, 1);
        errs(31, 1);
        cyc(1, 0, 1, 0, 0);
        checks++; if (TEC !== 9'd256 || ERR_STATE !== 2'b10) begin
            errors++; $display("FAIL busoff_tec: got tec=%0d state=%b want 256 10", TEC, ERR_STATE);
        end
        cyc(0, 0, 1, 0, 0);
        checks++; if (FLAG_TX !== 1'b0 || DELIM_TX !== 1'b0) begin
            errors++; $display("FAIL busoff_flags: got flag=%b delim=%b want 0 0", FLAG_TX, DELIM_TX);
        end
        repeat (4) cyc(1, 1, 1, 0, 0);
        checks++; if (TEC !== 9'd256 || REC !== 8'd0) begin
            errors++; $display("FAIL busoff_ignore: got tec=%0d rec=%0d want 256 0", TEC, REC);
        end
        repeat (5) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        repeat (128 * 11 - 1) cyc(0, 0, 0, 1, 0);
        checks++; if (ERR_STATE !== 2'b10) begin errors++; $display("FAIL busoff_early: got %b want 10", ERR_STATE); end
        cyc(0, 0, 0, 1, 0);
        checks++; if (TEC !== 9'd0 || REC !== 8'd0 || ERR_STATE !== 2'b00) begin
            errors++; $display("FAIL busoff_recover: got tec=%0d rec=%0d state=%b want 0 0 00", TEC, REC, ERR_STATE);
        end
        cyc(1, 0, 1, 1, 0);
        checks++; if (FLAG_TX !== 1'b1 || TEC !== 9'd8) begin
            errors++; $display("FAIL busoff_after: got flag=%b tec=%0d want 1 8", FLAG_TX, TEC);
        end
    endtask

    task automatic test_reset_mid_delim();
        cyc(0, 0, 0, 1, 1);
        errs(4, 1);
        cyc(1, 0, 1, 0, 0);
        repeat (FL + 1) cyc(0, 0, 1, 0, 0);
        checks++; if (DELIM_TX !== 1'b1 || TEC !== 9'd40) begin
            errors++; $display("FAIL mid_delim_setup: got delim=%b tec=%0d want 1 40", DELIM_TX, TEC);
        end
        cyc(1, 1, 1, 0, 1);
        checks++; if ({TEC, REC, ERR_STATE, FLAG_TX, DELIM_TX, FLAG_PASSIVE} !== '0) begin
            errors++; $display("FAIL mid_delim_reset: got tec=%0d rec=%0d state=%b flag=%b delim=%b fpass=%b want all 0",
                               TEC, REC, ERR_STATE, FLAG_TX, DELIM_TX, FLAG_PASSIVE);
        end
    endtask

    task automatic test_random();
        bit err, fok, tx, rx, rst;
        int bad;
        cyc(0, 0, 0, 1, 1);
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            err = $urandom_range(0, 5) == 0;
            fok = $urandom_range(0, 2) == 0;
            tx  = $urandom_range(0, 1) == 0;
            rx  = $urandom_range(0, 7) != 0;
            rst = $urandom_range(0, 399) == 0;
            cyc(err, fok, tx, rx, rst);
            checks++;
            if (TEC !== 9'(m_tec) || REC !== 8'(m_rec) || ERR_STATE !== m_state() ||
                FLAG_TX !== (!m_boff && m_busy > DL) || DELIM_TX !== (!m_boff && m_busy > 0 && m_busy <= DL) ||
                FLAG_PASSIVE !== m_fpass) begin
                errors++;
                if (bad++ < 10)
                    $display("FAIL random[%0d]: got tec=%0d rec=%0d st=%b f=%b d=%b p=%b want %0d %0d %b %b %b %b", i,
                             TEC, REC, ERR_STATE, FLAG_TX, DELIM_TX, FLAG_PASSIVE, m_tec, m_rec, m_state(),
                             !m_boff && m_busy > DL, !m_boff && m_busy > 0 && m_busy <= DL, m_fpass);
            end
`ifdef ERR_WARNING_EN
            checks++;
            if (ERR_WARN !== (m_tec >= 96 || m_rec >= 96)) begin
                errors++; $display("FAIL warn[%0d]: got %b want %b", i, ERR_WARN, m_tec >= 96 || m_rec >= 96);
            end
`endif
        end
    endtask

    task automatic test_warn();
`ifdef ERR_WARNING_EN
        cyc(0, 0, 0, 1, 1);
        errs(11, 1);
        checks++; if (ERR_WARN !== 1'b0) begin errors++; $display("FAIL warn_88: got %b want 0", ERR_WARN); end
        errs(1, 1);
        checks++; if (TEC !== 9'd96 || ERR_WARN !== 1'b1) begin
            errors++; $display("FAIL warn_96: got tec=%0d warn=%b want 96 1", TEC, ERR_WARN);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_tx_error();
        test_passive();
        test_rec_restore();
        test_err_and_ok();
        test_busoff();
        test_reset_mid_delim();
        test_warn();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/error_confinement_ctrl.md
ERROR_CONFINEMENT_CTRL -- requirements
Module: error_confinement_ctrl

Interface
REQ-001 The block SHALL have parameter FLAG_LEN, default 6, meaning error flag length in bit times.
REQ-002 The block SHALL have parameter DELIM_LEN, default 8, meaning error delimiter length in bit times.
REQ-003 The block SHALL have ports:
- SP  in  1  clock, one rising edge per bit sample point; the only clock.
- reset  in  1  reset, synchronous, active-high.
- STF_E, EOF_E, CRC_E, FRM_E  in  1 each  error flags, active-low: 0 = error this bit.
- TX_MODE  in  1  1 = node is current transmitter.
- FRAME_OK  in  1  one-SP pulse on a frame that completed without error.
- RX_BIT  in  1  sampled bus level, 1 = recessive.
- TEC  out  9  transmit error count.
- REC  out  8  receive error count.
- ERR_STATE  out  2  00 active, 01 passive, 10 bus-off.
- FLAG_TX  out  1  1 while the error flag is being driven.
- FLAG_PASSIVE  out  1  flag type: 0 dominant (active flag), 1 recessive (passive flag).
- DELIM_TX  out  1  1 during the error delimiter.

Function
REQ-004 An error event (ERR_EV) SHALL be any of STF_E, EOF_E, CRC_E or FRM_E equal to 0 at an SP edge.
REQ-005 The FSM SHALL have states IDLE, FLAG, DELIM, BUSOFF.
REQ-006 In IDLE, ERR_EV SHALL cause a transition to FLAG on the same edge and load the bit counter with FLAG_LEN-1.
REQ-007 FLAG SHALL last exactly FLAG_LEN SP cycles, then DELIM SHALL last exactly DELIM_LEN cycles, then the FSM SHALL return to IDLE.
REQ-008 FLAG_TX and DELIM_TX SHALL be registered decodes of FLAG and DELIM, asserted from the first SP cycle of each state.
REQ-009 FLAG_PASSIVE SHALL be latched at entry to FLAG as (ERR_STATE==passive).
REQ-010 On entry to FLAG: if TX_MODE=1, TEC += 8; otherwise REC += 1.
REQ-011 ERR_EV during FLAG or DELIM SHALL be ignored: no counter change and no restart.
REQ-012 In IDLE, FRAME_OK without ERR_EV SHALL decrement TEC by 1 when TX_MODE=1 and TEC>0.
REQ-013 In IDLE, FRAME_OK without ERR_EV and with TX_MODE=0 SHALL apply to REC: if REC in 1..127, REC -= 1; if REC>127, REC = 120; if REC=0, no change.
REQ-014 If ERR_EV and FRAME_OK occur on the same edge, ERR_EV SHALL win and no decrement SHALL occur.
REQ-015 TEC SHALL saturate at 256; REC SHALL saturate at 255. Counters SHALL never wrap.
REQ-016 ERR_STATE SHALL be combinational from the counters:
- bus-off if TEC>=256;
- else passive if TEC>=128 or REC>=128;
- else active.
REQ-017 When TEC reaches 256, the FSM SHALL enter BUSOFF on the next edge, overriding FLAG and DELIM, and FLAG_TX and DELIM_TX SHALL deassert.
REQ-018 In BUSOFF, the FSM SHALL count sequences of 11 consecutive RX_BIT=1; any RX_BIT=0 SHALL clear the consecutive-bit count but not the sequence count.
REQ-019 On completion of the 128th sequence, TEC and REC SHALL be cleared and the FSM SHALL go to IDLE (error-active).
REQ-020 In BUSOFF, ERR_EV and FRAME_OK SHALL be ignored.

Reset
REQ-021 With reset=1 at an SP edge, the FSM SHALL go to IDLE.
REQ-022 Reset SHALL clear TEC, REC, the bit counter and the recovery counters, and set FLAG_TX=0, DELIM_TX=0, FLAG_PASSIVE=0, ERR_STATE=00.
REQ-023 Reset SHALL take priority over all events, including mid-FLAG, mid-DELIM and BUSOFF.

Configuration
REQ-024 With macro ERR_WARNING_EN defined, the block SHALL add output ERR_WARN (1 bit), asserted combinationally when TEC>=96 or REC>=96.
REQ-025 With ERR_WARNING_EN undefined, the port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package can_err_pkg SHALL hold:
- the FSM state enum;
- the ERR_STATE encodings;
- the constants TEC_INC=8, PASSIVE_LIM=128, BUSOFF_LIM=256, WARN_LIM=96, REC_RESTORE=120, RECOV_BITS=11 and RECOV_SEQ=128.
REQ-027 The bus-off recovery counting (11-bit and 128-sequence counters) SHALL be a sub-module can_busoff_recovery with inputs SP, reset, enable, RX_BIT and a one-cycle done output.

Verification
REQ-028 Set CRC_E=0 for one SP with TX_MODE=1 and TEC=0 -> FLAG_TX high for 6 cycles, then DELIM_TX high for 8 cycles; TEC=8; FLAG_PASSIVE=0.
REQ-029 Apply 16 transmit errors -> TEC=128, ERR_STATE=01; the next error frame has FLAG_PASSIVE=1.
REQ-030 Set REC=130, then FRAME_OK with TX_MODE=0 -> REC=120, ERR_STATE=00. Set REC=0, then FRAME_OK -> REC stays 0.
REQ-031 Apply 32 transmit errors -> TEC=256, BUSOFF; drive 128×11 recessive bits with a dominant bit inserted mid-sequence -> recovery completes only after 128 full sequences, then TEC=REC=0 and ERR_STATE=00.
REQ-032 Apply FRM_E=0 and FRAME_OK on the same edge with TEC=10 -> TEC=18. Apply ERR_EV at FLAG cycle 3 -> TEC unchanged and the flag length is still 6.
REQ-033 Assert reset during DELIM with TEC=40 -> next cycle is IDLE with all outputs 0. With ERR_WARNING_EN defined, TEC=96 -> ERR_WARN=1.
